// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against an internal word RAM.
// Latency: rsp_valid rises 2 edges after accept for legal requests, 1 edge for errors.
// Backpressure: the response is held stable until rsp_ready; no new request is taken before that.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready - request handshake; req_ready is high only in IDLE
//   req_we              - 1 = store, 0 = load
//   req_size            - 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        - load zero-extends when 1, sign-extends when 0 (ignored for word)
//   req_addr            - byte address
//   req_wdata           - right-aligned store data
//   rsp_valid/rsp_ready - response handshake
//   rsp_rdata           - extended load result; 0 for stores and errors
//   rsp_err             - misaligned, out-of-range or illegal-size request
module dmem_responder #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Captured request fields
    logic          we_q,    we_d;
    logic [1:0]    size_q,  size_d;
    logic          uns_q,   uns_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic [1:0]    lane_q,  lane_d;
    logic [31:0]   wdata_q, wdata_d;

    // Response registers
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q,   err_d;

    // Storage: not reset, contents survive rst_n
    logic [31:0]   mem [DEPTH];

    logic          req_bad;
    logic          accept;
    logic          rsp_fire;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wd;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   ld_ext;

    assign accept   = (state_q == IDLE) && req_valid;
    assign rsp_fire = (state_q == RESP) && rsp_ready;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Request legality, evaluated on the live request bus at accept time
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SZ_HALF: req_bad = req_addr[0];
            SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
            SZ_BYTE: req_bad = 1'b0;
            default: req_bad = 1'b1;
        endcase
        if (req_addr[31:2] >= DEPTH_W) begin
            req_bad = 1'b1;
        end
    end

    // Store lane enables and lane-replicated data; replication lets each
    // enabled lane simply take its own byte slice.
    always_comb begin
        ram_be = 4'b0000;
        ram_wd = wdata_q;
        case (size_q)
            SZ_BYTE: begin
                ram_be = 4'b0001 << lane_q;
                ram_wd = {4{wdata_q[7:0]}};
            end
            SZ_HALF: begin
                ram_be = lane_q[1] ? 4'b1100 : 4'b0011;
                ram_wd = {2{wdata_q[15:0]}};
            end
            SZ_WORD: begin
                ram_be = 4'b1111;
                ram_wd = wdata_q;
            end
            default: begin
                ram_be = 4'b0000;
                ram_wd = wdata_q;
            end
        endcase
    end

    // Erroneous requests never reach ACCESS, so no extra error gating here.
    // Reset forces IDLE asynchronously, which cancels a write still pending in ACCESS.
    assign ram_we = (state_q == ACCESS) && we_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[idx_q][8*i +: 8] <= ram_wd[8*i +: 8];
                end
            end
        end
    end

    // Load path: extract the addressed lane(s) and extend
    assign rd_word = mem[idx_q];
    assign rd_byte = rd_word[8*lane_q +: 8];
    assign rd_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_ext = rd_word;
        case (size_q)
            SZ_BYTE: ld_ext = uns_q ? {24'h000000, rd_byte}
                                    : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: ld_ext = uns_q ? {16'h0000, rd_half}
                                    : {{16{rd_half[15]}}, rd_half};
            default: ld_ext = rd_word;
        endcase
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    idx_d   = req_addr[AW+1:2];
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_bad;
                    state_d = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = we_q ? 32'h0 : ld_ext;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // accept/rsp_fire are kept as readable names for the handshake edges
    logic unused_hs;
    assign unused_hs = accept ^ rsp_fire;

endmodule
